// File: rtl/ring_rr_arbiter_pkg.sv
// rtl/ring_rr_arbiter_pkg.sv - shared types and helper functions for the ring round-robin arbiter
// Package ring_arb_pkg.
//   arb_state_e  : arbiter FSM states (ST_IDLE, ST_GRANT)
//   rotl_onehot  : rotate an n-bit one-hot vector left by one, bit n-1 wraps to bit 0
//   onehot2bin   : binary index of the set bit of a one-hot vector
//   rr_pick      : first set request at or above the token bit, wrapping at n; 0 if none
// Functions work on ARB_MAX_N-bit vectors with the active width n passed in,
// so callers zero-extend their N-bit vectors and truncate the result.
package ring_arb_pkg;

  localparam int ARB_MAX_N = 32;
  localparam int ARB_IW    = 5;

  typedef logic [ARB_MAX_N-1:0] arb_vec_t;
  typedef logic [ARB_IW:0]      arb_cnt_t;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_e;

  function automatic arb_vec_t rotl_onehot(input arb_vec_t v, input arb_cnt_t n);
    arb_vec_t r;
    arb_cnt_t top;
    r = '0;
    for (int i = 1; i < ARB_MAX_N; i++) begin
      if (arb_cnt_t'(i) < n) r[i] = v[i-1];
    end
    top  = n - arb_cnt_t'(1);
    r[0] = v[top[ARB_IW-1:0]];
    return r;
  endfunction

  function automatic logic [ARB_IW-1:0] onehot2bin(input arb_vec_t v);
    logic [ARB_IW-1:0] b;
    b = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (v[i]) b = b | ARB_IW'(i);
    end
    return b;
  endfunction

  function automatic arb_vec_t rr_pick(input arb_vec_t req, input arb_vec_t tok,
                                       input arb_cnt_t n);
    arb_vec_t win;
    arb_cnt_t start;
    arb_cnt_t idx;
    logic     found;
    win   = '0;
    start = '0;
    found = 1'b0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (tok[i]) start = arb_cnt_t'(i);
    end
    // Walk n positions starting at the token; start + k never exceeds 2n-2,
    // so a single conditional subtract is enough for the wrap.
    for (int k = 0; k < ARB_MAX_N; k++) begin
      idx = start + arb_cnt_t'(k);
      if (idx >= n) idx = idx - n;
      if (!found && (arb_cnt_t'(k) < n) && req[idx[ARB_IW-1:0]]) begin
        win[idx[ARB_IW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// rtl/ring_rr_arbiter_if.sv - request/grant bundle between requesters and the arbiter
// Signals:
//   in_req   [N]    level requests, one per requester
//   o_gnt    [N]    one-hot grant, all-zero when idle
//   o_gnt_id [IDW]  binary index of the owner, 0 when idle
//   o_busy          any grant active
// Modports: master = requester side, slave = arbiter side.
interface ring_rr_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);

  logic [N-1:0]   in_req;
  logic [N-1:0]   o_gnt;
  logic [IDW-1:0] o_gnt_id;
  logic           o_busy;

  modport master (output in_req, input o_gnt, input o_gnt_id, input o_busy);
  modport slave  (input in_req, output o_gnt, output o_gnt_id, output o_busy);

endinterface

// File: rtl/ring_rr_arbiter_token.sv
// rtl/ring_rr_arbiter_token.sv - one-hot rotating token register that seeds the winner search
// Module ring_token.
// Ports:
//   in_clk    clock, rising edge
//   in_rst_n  asynchronous active-low reset, token returns to bit 0
//   in_clr    synchronous clear, token returns to bit 0 (beats in_load)
//   in_load   load in_val into the token
//   in_val    next token value, one-hot
//   o_tok     current token, one-hot
module ring_token #(
  parameter int N = 4
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  input  logic         in_clr,
  input  logic         in_load,
  input  logic [N-1:0] in_val,
  output logic [N-1:0] o_tok
);

  localparam logic [N-1:0] SEED = N'(1);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      o_tok <= SEED;
    end else if (in_clr) begin
      o_tok <= SEED;
    end else if (in_load) begin
      o_tok <= in_val;
    end
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// rtl/ring_rr_arbiter.sv - round-robin arbiter with one-hot token ring and held grants
// Top module ring_rr_arbiter. Optional feature macro: ARB_HOLD_LIMIT_EN (hold-time revoke).
// Ports:
//   in_clk    clock, rising edge
//   in_rst_n  asynchronous active-low reset
//   in_clr    synchronous clear: drop grant, re-seed token to bit 0
//   arb       ring_rr_arbiter_if.slave: in_req in, o_gnt / o_gnt_id / o_busy out (all registered)
// An owner keeps the grant while its request stays high. On release (or revoke when
// ARB_HOLD_LIMIT_EN is defined) the token moves just past the owner and the search from
// that new token runs in the same cycle, so a waiting requester takes over without an idle cycle.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = 8
) (
  input logic              in_clk,
  input logic              in_rst_n,
  input logic              in_clr,
  ring_rr_arbiter_if.slave arb
);

  localparam arb_cnt_t NW = arb_cnt_t'(N);

  arb_state_e     st_q, st_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic           busy_q, busy_d;
  logic [N-1:0]   tok, tok_val, search_tok, pick;
  logic           tok_load;
  logic           owner_req;
  logic           revoke;
  logic           hand_off;

  ring_token #(.N(N)) u_token (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .in_clr   (in_clr),
    .in_load  (tok_load),
    .in_val   (tok_val),
    .o_tok    (tok)
  );

  assign owner_req = |(arb.in_req & gnt_q);
  assign tok_val   = N'(rotl_onehot(ARB_MAX_N'(gnt_q), NW));

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          others_req;

  assign others_req = |(arb.in_req & ~gnt_q);
  // Revoke only when someone else is waiting; otherwise the owner keeps going
  // and the counter just sits at MAX_HOLD.
  assign revoke = (st_q == ST_GRANT) && owner_req && others_req && (hold_q >= HW'(MAX_HOLD));
`else
  localparam int unused_max_hold = MAX_HOLD;
  assign revoke = 1'b0;
`endif

  assign hand_off   = (st_q == ST_GRANT) && (!owner_req || revoke);
  // The outgoing owner sits last in the search from rotl(owner), so it only
  // wins back on revoke when nobody else asks, which revoke already excludes.
  assign search_tok = hand_off ? tok_val : tok;
  assign pick       = N'(rr_pick(ARB_MAX_N'(arb.in_req), ARB_MAX_N'(search_tok), NW));

  always_comb begin
    st_d     = st_q;
    gnt_d    = gnt_q;
    tok_load = 1'b0;
    if (in_clr) begin
      st_d  = ST_IDLE;
      gnt_d = '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (|arb.in_req) begin
            gnt_d = pick;
            st_d  = ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (hand_off) begin
            tok_load = 1'b1;
            gnt_d    = pick;
            st_d     = (|pick) ? ST_GRANT : ST_IDLE;
          end
        end
        default: begin
          st_d  = ST_IDLE;
          gnt_d = '0;
        end
      endcase
    end
  end

  assign id_d   = IDW'(onehot2bin(ARB_MAX_N'(gnt_d)));
  assign busy_d = |gnt_d;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      st_q   <= ST_IDLE;
      gnt_q  <= '0;
      id_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      id_q   <= id_d;
      busy_q <= busy_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  // Counts grant cycles of the current owner; 1 on the first cycle of every new grant.
  always_comb begin
    hold_d = hold_q;
    if (in_clr) begin
      hold_d = '0;
    end else if (st_q == ST_IDLE) begin
      hold_d = (|arb.in_req) ? HW'(1) : '0;
    end else if (hand_off) begin
      hold_d = (|pick) ? HW'(1) : '0;
    end else if (hold_q < HW'(MAX_HOLD)) begin
      hold_d = hold_q + HW'(1);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign arb.o_gnt    = gnt_q;
  assign arb.o_gnt_id = id_q;
  assign arb.o_busy   = busy_q;

endmodule
